// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexed scan of 2**N seven-segment digits. A prescale counter
// paces the digit-select counter; the digit word is captured once per frame
// (at cnt==0, sel==0) so a frame never shows a mix of old and new values.
// All outputs are registered and reflect the previous cycle's sel/enable/blank.
module display_scan_controller #(
   parameter int N        = 2,
   parameter int PRESCALE = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [4*(2**N)-1:0] digits,
   input  logic [(2**N)-1:0]   blank,
   output logic [(2**N)-1:0]   anodes_n,
   output logic [6:0]       segments_n,
   output logic [N-1:0]     digit_sel,
   output logic             frame_done
);

   localparam int D  = 2**N;
   localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

   logic [CW-1:0]  cnt;
   logic [N-1:0]   sel;
   logic [4*D-1:0] shd;

   logic           load;
   logic           slot_end;
   logic           lit;
   logic [3:0]     v;
   logic [D-1:0]   an_next;
   logic [6:0]     seg_next;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Frame-load / slot-end decode and next values for the output registers.
   // On a load cycle the shadow is not yet written, so the live word is shown.
   always_comb begin
      load     = 1'b0;
      slot_end = 1'b0;
      lit      = 1'b0;
      v        = '0;
      an_next  = '1;
      seg_next = '1;
      load     = enable && (cnt == '0) && (sel == '0);
      slot_end = (cnt == CNT_MAX);
      lit      = enable && !blank[sel];
      v        = load ? digits[4*sel +: 4] : shd[4*sel +: 4];
      for (int unsigned i = 0; i < D; i++) begin
         an_next[i] = !(lit && (sel == N'(i)));
      end
      seg_next = lit ? hex7(v) : 7'b1111111;
   end

   // Counters, shadow capture and registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         sel        <= '0;
         shd        <= '0;
         anodes_n   <= '1;
         segments_n <= '1;
         digit_sel  <= '0;
         frame_done <= 1'b0;
      end else begin
         if (enable) begin
            if (slot_end) begin
               cnt <= '0;
               sel <= sel + 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (load) begin
            shd <= digits;
         end
         anodes_n   <= an_next;
         segments_n <= seg_next;
         digit_sel  <= sel;
         frame_done <= enable && slot_end && (sel == N'(D - 1));
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (N=2, PRESCALE=4).
// Reference model tracks a single frame position counter in enabled cycles
// and derives digit index / slot boundaries arithmetically.
module tb_display_scan_controller;

   localparam int N  = 2;
   localparam int P  = 4;
   localparam int D  = 4;
   localparam int FP = D * P;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic [3:0]  anodes_n;
   logic [6:0]  segments_n;
   logic [1:0]  digit_sel;
   logic        frame_done;

   display_scan_controller #(.N(N), .PRESCALE(P)) dut (
      .clk(clk), .reset(reset), .enable(enable), .digits(digits),
      .blank(blank), .anodes_n(anodes_n), .segments_n(segments_n),
      .digit_sel(digit_sel), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] hex_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110 };

   // model state
   int          pos;
   logic [15:0] m_shd;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic [1:0]  e_sel;
   logic        e_fd;

   // Predict outputs for the coming edge from current inputs, then advance.
   task automatic model_edge();
      int s;
      bit ld;
      logic [3:0] v;
      if (reset) begin
         pos = 0; m_shd = '0;
         e_an = 4'hF; e_seg = 7'h7F; e_sel = 0; e_fd = 0;
      end else begin
         s  = pos / P;
         ld = enable && (pos == 0);
         v  = ld ? digits[4*s +: 4] : m_shd[4*s +: 4];
         e_sel = 2'(s);
         e_an  = 4'hF;
         e_seg = 7'h7F;
         if (enable && !blank[s]) begin
            e_an[s] = 1'b0;
            e_seg   = hex_tab[v];
         end
         e_fd = enable && (pos == FP - 1);
         if (ld) m_shd = digits;
         if (enable) pos = (pos + 1) % FP;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      enable = 1'b1; blank = '0; digits = 16'h3A07;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({anodes_n, segments_n, digit_sel, frame_done} !== {4'hF, 7'h7F, 2'd0, 1'b0}) begin
            $display("FAIL reset: got an=%b seg=%b sel=%0d fd=%b, expected an=1111 seg=1111111 sel=0 fd=0",
                     anodes_n, segments_n, digit_sel, frame_done);
            n_fail++;
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_scan();
      logic [3:0] tab_an [4];
      logic [6:0] tab_seg [4];
      int fd_count;
      tab_an[0] = 4'b1110; tab_seg[0] = 7'b1111000;
      tab_an[1] = 4'b1101; tab_seg[1] = 7'b1000000;
      tab_an[2] = 4'b1011; tab_seg[2] = 7'b0001000;
      tab_an[3] = 4'b0111; tab_seg[3] = 7'b0110000;
      enable = 1'b1; blank = '0; digits = 16'h3A07;
      do_reset(2);
      fd_count = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         fd_count += int'(frame_done);
         n_checks++;
         if ({anodes_n, segments_n} !== {tab_an[(k-1)/P], tab_seg[(k-1)/P]}) begin
            $display("FAIL scan_table cycle %0d: got an=%b seg=%b, expected an=%b seg=%b",
                     k, anodes_n, segments_n, tab_an[(k-1)/P], tab_seg[(k-1)/P]);
            n_fail++;
         end
         n_checks++;
         if ({anodes_n, segments_n, digit_sel, frame_done} !== {e_an, e_seg, e_sel, e_fd}) begin
            $display("FAIL scan_model cycle %0d: got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                     k, anodes_n, segments_n, digit_sel, frame_done, e_an, e_seg, e_sel, e_fd);
            n_fail++;
         end
      end
      tick();
      fd_count += int'(frame_done);
      n_checks++;
      if (fd_count !== 1) begin
         $display("FAIL scan_frame_done_count: got %0d pulses, expected 1", fd_count);
         n_fail++;
      end
   endtask

   task automatic test_antitear();
      enable = 1'b1; blank = '0; digits = 16'h3A07;
      do_reset(2);
      for (int k = 1; k <= 2 * FP + 2; k++) begin
         if (k == 6) digits = 16'hFFFF;
         tick();
         n_checks++;
         if ({anodes_n, segments_n, digit_sel, frame_done} !== {e_an, e_seg, e_sel, e_fd}) begin
            $display("FAIL antitear cycle %0d: got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                     k, anodes_n, segments_n, digit_sel, frame_done, e_an, e_seg, e_sel, e_fd);
            n_fail++;
         end
      end
   endtask

   task automatic test_blank();
      enable = 1'b1; blank = 4'b0010; digits = 16'h3A07;
      do_reset(2);
      for (int k = 1; k <= FP + 1; k++) begin
         tick();
         n_checks++;
         if ({anodes_n, segments_n, digit_sel, frame_done} !== {e_an, e_seg, e_sel, e_fd}) begin
            $display("FAIL blank cycle %0d: got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                     k, anodes_n, segments_n, digit_sel, frame_done, e_an, e_seg, e_sel, e_fd);
            n_fail++;
         end
      end
      blank = '0;
   endtask

   task automatic test_pause();
      enable = 1'b1; blank = '0; digits = 16'h3A07;
      do_reset(2);
      for (int k = 1; k <= 10 + 5 + 10; k++) begin
         enable = !(k > 10 && k <= 15);
         tick();
         n_checks++;
         if ({anodes_n, segments_n, digit_sel, frame_done} !== {e_an, e_seg, e_sel, e_fd}) begin
            $display("FAIL pause cycle %0d: got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                     k, anodes_n, segments_n, digit_sel, frame_done, e_an, e_seg, e_sel, e_fd);
            n_fail++;
         end
      end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      enable = 1'b1; blank = '0; digits = 16'h3A07;
      do_reset(2);
      for (int k = 1; k <= 24; k++) begin
         reset = (k == 14);
         if (k == 15) digits = 16'h1234;
         tick();
         n_checks++;
         if ({anodes_n, segments_n, digit_sel, frame_done} !== {e_an, e_seg, e_sel, e_fd}) begin
            $display("FAIL reset_mid cycle %0d: got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                     k, anodes_n, segments_n, digit_sel, frame_done, e_an, e_seg, e_sel, e_fd);
            n_fail++;
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      enable = 1'b1; blank = '0; digits = 16'(urand16());
      do_reset(1);
      for (int k = 1; k <= 400; k++) begin
         reset  = ($urandom_range(0, 99) == 0);
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) blank = 4'($urandom_range(0, 15));
         digits = urand16();
         tick();
         n_checks++;
         if ({anodes_n, segments_n, digit_sel, frame_done} !== {e_an, e_seg, e_sel, e_fd}) begin
            $display("FAIL random cycle %0d: got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                     k, anodes_n, segments_n, digit_sel, frame_done, e_an, e_seg, e_sel, e_fd);
            n_fail++;
         end
      end
      reset = 1'b0;
   endtask

   function automatic logic [15:0] urand16();
      return 16'($urandom_range(0, 65535));
   endfunction

   initial begin
      reset = 1'b1; enable = 1'b0; blank = '0; digits = '0;
      pos = 0; m_shd = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_sel = 0; e_fd = 0;
      #1;
      test_reset();
      test_scan();
      test_antitear();
      test_blank();
      test_pause();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
